// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the buffered UART.
package uart_pkg;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_DIV  = 3'd2;

  // STATUS register bit positions (TX-only UART compatible layout)
  localparam int unsigned ST_RX_NE   = 8;
  localparam int unsigned ST_RX_OVR  = 9;
  localparam int unsigned ST_FRAME   = 10;
  localparam int unsigned ST_TX_DROP = 11;
  localparam int unsigned ST_TX_NF   = 13;
  localparam int unsigned ST_TX_IDLE = 14;

  // Smallest divisor the hardware accepts
  localparam int unsigned DIV_MIN = 4;

  typedef enum logic {
    TxIdle,
    TxShift
  } tx_state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Show-ahead synchronous FIFO; push while full is accepted only alongside a pop.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Flags from pointer compare; MSB distinguishes full from empty
  always_comb begin
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wptr_d  = wptr_q + PW'(do_push);
    rptr_d  = rptr_q + PW'(do_pop);
    dout    = mem_q[rptr_q[AW-1:0]];
  end

  // Pointer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array, no reset needed: reads are gated by empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Buffered 8N1 UART with TX/RX FIFOs, programmable divisor and sticky error flags.
module uart_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DIV_RESET = 433,
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned TX_DEPTH  = 16,
  parameter int unsigned RX_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic        wr,
  input  logic        valid,
  input  logic        rxd,
  output logic        txd
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [31:0]      dout_q, dout_d, rd_data, status;
  logic             ovr_q, ovr_d, frm_q, frm_d, drop_q, drop_d;
  logic             bus_rd, bus_wr, stat_rd;
  logic             unused_din;

  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]       tx_head;
  tx_state_e        tx_state_q;
  logic [9:0]       tx_shift_q;
  logic [DIV_W-1:0] tx_cnt_q, tx_div_q;
  logic [3:0]       tx_bit_q;
  logic             tx_bit_end, tx_load;

  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]       rx_head, rx_data_q;
  logic             rx_s1_q, rx_s2_q;
  rx_state_e        rx_state_q;
  logic [DIV_W-1:0] rx_cnt_q, rx_div_q;
  logic [2:0]       rx_bit_q;
  logic             rx_sample, rx_stop_evt, ovr_set, frm_set, drop_set;

  assign unused_din = ^din;
  assign dout       = dout_q;
  assign txd        = tx_shift_q[0];

  uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (tx_push),
    .pop  (tx_pop),
    .din  (din[7:0]),
    .dout (tx_head),
    .full (tx_full),
    .empty(tx_empty)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (rx_push),
    .pop  (rx_pop),
    .din  (rx_data_q),
    .dout (rx_head),
    .full (rx_full),
    .empty(rx_empty)
  );

  // Bus decode, read mux, divisor clamp and sticky flag next-state (set beats clear)
  always_comb begin
    bus_rd  = valid && !wr;
    bus_wr  = valid && wr;
    tx_push = bus_wr && (addr == ADDR_DATA);
    rx_pop  = bus_rd && (addr == ADDR_DATA) && !rx_empty;
    stat_rd = bus_rd && addr[2];

    status             = '0;
    status[ST_RX_NE]   = !rx_empty;
    status[ST_RX_OVR]  = ovr_q;
    status[ST_FRAME]   = frm_q;
    status[ST_TX_DROP] = drop_q;
    status[ST_TX_NF]   = !tx_full;
    status[ST_TX_IDLE] = tx_empty && (tx_state_q == TxIdle);

    rd_data = '0;
    if (addr[2])                rd_data = status;
    else if (addr == ADDR_DATA) rd_data = rx_empty ? 32'd0 : {24'd0, rx_head};
    else if (addr == ADDR_DIV)  rd_data = 32'(div_q);
    dout_d = valid ? rd_data : dout_q;

    div_d = div_q;
    if (bus_wr && (addr == ADDR_DIV)) begin
      div_d = (din[DIV_W-1:0] < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : din[DIV_W-1:0];
    end

    drop_set = tx_push && tx_full && !tx_pop;
    drop_d   = drop_set || (drop_q && !stat_rd);
    ovr_d    = ovr_set || (ovr_q && !stat_rd);
    frm_d    = frm_set || (frm_q && !stat_rd);
  end

  // Bus-side registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      div_q  <= DIV_W'(DIV_RESET);
      ovr_q  <= 1'b0;
      frm_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      div_q  <= div_d;
      ovr_q  <= ovr_d;
      frm_q  <= frm_d;
      drop_q <= drop_d;
    end
  end

  // TX load happens from idle or straight out of the stop bit, so frames abut
  always_comb begin
    tx_bit_end = (tx_cnt_q == tx_div_q);
    tx_load    = !tx_empty && ((tx_state_q == TxIdle) ||
                               (tx_bit_end && (tx_bit_q == 4'd9)));
    tx_pop     = tx_load;
  end

  // TX FSM: shifter idles at all-ones so txd rests high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TxIdle;
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_div_q   <= DIV_W'(DIV_RESET);
    end else if (tx_load) begin
      tx_state_q <= TxShift;
      tx_shift_q <= {1'b1, tx_head, 1'b0};
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_div_q   <= div_q;
    end else if (tx_state_q == TxShift) begin
      if (tx_bit_end) begin
        tx_cnt_q   <= '0;
        tx_shift_q <= {1'b1, tx_shift_q[9:1]};
        tx_bit_q   <= tx_bit_q + 4'd1;
        if (tx_bit_q == 4'd9) tx_state_q <= TxIdle;
      end else begin
        tx_cnt_q <= tx_cnt_q + DIV_W'(1);
      end
    end
  end

  // Two-flop synchronizer for the asynchronous serial input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rxd;
      rx_s2_q <= rx_s1_q;
    end
  end

  // Stop-bit outcome; a same-cycle DATA pop frees the slot and avoids overrun
  always_comb begin
    rx_sample   = (rx_cnt_q == rx_div_q);
    rx_stop_evt = (rx_state_q == RxStop) && rx_sample;
    rx_push     = rx_stop_evt && rx_s2_q && (!rx_full || rx_pop);
    ovr_set     = rx_stop_evt && rx_s2_q && rx_full && !rx_pop;
    frm_set     = rx_stop_evt && !rx_s2_q;
  end

  // RX FSM: half-bit start qualification, then one sample per bit period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_div_q   <= DIV_W'(DIV_RESET);
      rx_bit_q   <= '0;
      rx_data_q  <= '0;
    end else begin
      unique case (rx_state_q)
        RxIdle: begin
          if (!rx_s2_q) begin
            rx_state_q <= RxStart;
            rx_cnt_q   <= '0;
            rx_div_q   <= div_q;
          end
        end
        RxStart: begin
          if (rx_cnt_q == (rx_div_q >> 1)) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s2_q ? RxIdle : RxData;
          end else begin
            rx_cnt_q <= rx_cnt_q + DIV_W'(1);
          end
        end
        RxData: begin
          if (rx_sample) begin
            rx_cnt_q  <= '0;
            rx_data_q <= {rx_s2_q, rx_data_q[7:1]};
            rx_bit_q  <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
          end else begin
            rx_cnt_q <= rx_cnt_q + DIV_W'(1);
          end
        end
        RxStop: begin
          if (rx_sample) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RxIdle;
          end else begin
            rx_cnt_q <= rx_cnt_q + DIV_W'(1);
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed-plus-random bench for uart_fifo_ctrl with a frame-level reference model.
module tb_uart_fifo_ctrl;

  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_DIV  = 3'd2;
  localparam logic [2:0] A_STAT = 3'd4;
  localparam int         DEPTH  = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        wr, valid;
  logic        rxd, txd;
  logic        rxd_drv, loop_en;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rxd = loop_en ? txd : rxd_drv;

  uart_fifo_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .addr (addr),
    .din  (din),
    .dout (dout),
    .wr   (wr),
    .valid(valid),
    .rxd  (rxd),
    .txd  (txd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    valid = 1'b1; wr = 1'b1; addr = a; din = d;
    @(negedge clk);
    valid = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    valid = 1'b1; wr = 1'b0; addr = a;
    @(negedge clk);
    valid = 1'b0;
    d = dout;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Line level of bit j of an 8N1 frame: start 0, data LSB first, stop 1
  function automatic logic frame_bit(input logic [7:0] b, input int j, input logic stop);
    if (j == 0) return 1'b0;
    if (j == 9) return stop;
    return b[j-1];
  endfunction

  // Compare txd at the middle of each bit of a frame whose start bit occupies cycle s
  task automatic check_tx_frame(input logic [7:0] b, input int s, input int d, input string tag);
    for (int j = 0; j < 10; j++) begin
      wait_cyc(s + j * (d + 1) + (d + 1) / 2);
      check($sformatf("%s_bit%0d", tag, j), {31'd0, txd}, {31'd0, frame_bit(b, j, 1'b1)});
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int d);
    for (int j = 0; j < 10; j++) begin
      rxd_drv = frame_bit(b, j, stop);
      repeat (d + 1) @(negedge clk);
    end
    rxd_drv = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    logic [7:0]  q[$];
    logic [31:0] dv;
    int          c, s, n_acc;
    logic        ovr_exp;

    rst_n = 1'b0; valid = 1'b0; wr = 1'b0; addr = '0; din = '0;
    rxd_drv = 1'b1; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_dout", dout, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bus_read(A_DIV, rd);  check("rst_div", rd, 32'd433);
    bus_read(A_STAT, rd); check("rst_status", rd, 32'h6000);

    // Single 0x55 frame at the reset divisor
    bus_write(A_DATA, 32'h55);
    c = cyc;
    check("tx_lat_t1", {31'd0, txd}, 32'd1);
    @(negedge clk);
    check("tx_lat_t2", {31'd0, txd}, 32'd0);
    check_tx_frame(8'h55, c + 1, 433, "f55");
    wait_cyc(c + 1 + 4340 + 2);
    bus_read(A_STAT, rd); check("status_after_55", rd, 32'h6000);

    // Back-to-back burst at DIV=9. The first byte moves into the shifter the
    // cycle after its write, so a burst holds DEPTH+1 bytes before dropping.
    bus_write(A_DIV, 32'd9);
    bus_read(A_DIV, rd); check("div9", rd, 32'd9);
    q.delete();
    @(negedge clk);
    valid = 1'b1; wr = 1'b1; addr = A_DATA;
    for (int i = 0; i < DEPTH + 2; i++) begin
      b = 8'($urandom);
      din = {24'd0, b};
      if (i < DEPTH + 1) q.push_back(b);
      @(negedge clk);
      if (i == 0) c = cyc;
    end
    valid = 1'b0; wr = 1'b0;
    n_acc = q.size();
    for (int k = 0; k < n_acc; k++) begin
      check_tx_frame(q[k], c + 1 + k * 100, 9, $sformatf("burst%0d", k));
    end
    wait_cyc(c + 1 + n_acc * 100 + 5);
    check("burst_idle_after", {31'd0, txd}, 32'd1);
    bus_read(A_STAT, rd); check("status_drop", rd, 32'h6800);
    bus_read(A_STAT, rd); check("status_drop_clr", rd, 32'h6000);

    // Loopback: 0xA3 plus two random bytes
    loop_en = 1'b1;
    q.delete();
    q.push_back(8'hA3);
    q.push_back(8'($urandom));
    q.push_back(8'($urandom));
    bus_write(A_DATA, {24'd0, q[0]});
    c = cyc;
    bus_write(A_DATA, {24'd0, q[1]});
    bus_write(A_DATA, {24'd0, q[2]});
    wait_cyc(c + 1 + 300 + 10);
    bus_read(A_STAT, rd); check("loop_status", rd, 32'h6100);
    while (q.size() > 0) begin
      bus_read(A_DATA, rd); check("loop_data", rd, {24'd0, q.pop_front()});
    end
    bus_read(A_STAT, rd); check("loop_status_empty", rd, 32'h6000);
    bus_read(A_DATA, rd); check("rx_empty_read", rd, 32'd0);
    loop_en = 1'b0;
    repeat (5) @(negedge clk);

    // Short low glitch is a false start
    rxd_drv = 1'b0;
    repeat (3) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (30) @(negedge clk);
    bus_read(A_STAT, rd); check("glitch_status", rd, 32'h6000);

    // Framing error: byte discarded, flag sticky until read
    send_frame(8'($urandom), 1'b0, 9);
    repeat (20) @(negedge clk);
    bus_read(A_STAT, rd); check("frame_err_status", rd, 32'h6400);
    bus_read(A_DATA, rd); check("frame_err_nodata", rd, 32'd0);
    bus_read(A_STAT, rd); check("frame_err_clr", rd, 32'h6000);

    // Overrun: DEPTH+1 frames with no reads
    q.delete();
    ovr_exp = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      if (q.size() < DEPTH) q.push_back(b);
      else ovr_exp = 1'b1;
      send_frame(b, 1'b1, 9);
    end
    repeat (10) @(negedge clk);
    bus_read(A_STAT, rd);
    check("ovr_status", rd, 32'h6100 | (32'(ovr_exp) << 9));
    while (q.size() > 0) begin
      bus_read(A_DATA, rd); check("ovr_data", rd, {24'd0, q.pop_front()});
    end
    bus_read(A_DATA, rd); check("ovr_drained", rd, 32'd0);
    bus_read(A_STAT, rd); check("ovr_clr", rd, 32'h6000);

    // Divisor clamp and plain write
    bus_write(A_DIV, 32'd2);
    bus_read(A_DIV, rd); check("div_clamp2", rd, 32'd4);
    dv = 32'($urandom_range(65535, 0));
    bus_write(A_DIV, dv);
    bus_read(A_DIV, rd); check("div_rand", rd, (dv < 4) ? 32'd4 : dv);

    // Asynchronous reset in the middle of a frame of zeros
    bus_write(A_DIV, 32'd9);
    bus_write(A_DATA, 32'h00);
    c = cyc;
    wait_cyc(c + 1 + 35);
    check("mid_frame_low", {31'd0, txd}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_txd", {31'd0, txd}, 32'd1);
    check("async_rst_dout", dout, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bus_read(A_DIV, rd);  check("rst_div_again", rd, 32'd433);
    bus_read(A_STAT, rd); check("rst_status_again", rd, 32'h6000);
    repeat (20) @(negedge clk);
    check("rst_line_idle", {31'd0, txd}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
